wb_image_loader: RTL and testbench

- Wishbone classic initiator that fills the 2 kB OpenRAM program store (512 x 32) from an 8-bit byte stream, e.g. bytes shifted in over GPIO.
- It is the initiator counterpart of the user-area Wishbone responder that decodes writes into the SRAM RW port.
- Packs bytes little-endian into 32-bit words and issues one single-beat write per word to consecutive word addresses from BASE_ADDR.
- Reports busy, done, error and the word count.

---
 rtl/wb_image_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_wb_image_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_image_loader.sv
// Wishbone classic initiator: packs an 8-bit stream little-endian into 32-bit words
// and writes them to consecutive word addresses. Define LOADER_READBACK_VERIFY_EN for read-back checking.
module wb_image_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned WORDS     = 512,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start,
  input  logic [7:0]  s_byte,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  words_written
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [9:0]    WORDS_LAST = 10'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef LOADER_READBACK_VERIFY_EN
    S_VERIFY  = 3'd5,
`endif
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t        r_state;
  logic [1:0]    r_byte_idx;
  logic [9:0]    r_word_cnt;
  logic [31:0]   r_word;
  logic [TW-1:0] r_tmo;
  logic          r_s_ready;
  logic          r_cyc;
  logic          r_stb;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_adr;
  logic [31:0]   r_dat;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [31:0]   w_word_next;
  logic [31:0]   w_adr;
  logic          w_tmo_hit;
  logic          w_last_word;

`ifndef LOADER_READBACK_VERIFY_EN
  logic          w_unused_dat;
  assign w_unused_dat = ^wbm_dat_i;
`endif

  assign w_adr       = BASE_ADDR + {20'd0, r_word_cnt, 2'b00};
  assign w_tmo_hit   = (r_tmo == TMO_LAST);
  assign w_last_word = (r_word_cnt == WORDS_LAST);

  // Merge the incoming byte into its little-endian lane of the word under assembly
  always_comb begin
    w_word_next = r_word;
    case (r_byte_idx)
      2'd0:    w_word_next[7:0]   = s_byte;
      2'd1:    w_word_next[15:8]  = s_byte;
      2'd2:    w_word_next[23:16] = s_byte;
      2'd3:    w_word_next[31:24] = s_byte;
      default: w_word_next        = r_word;
    endcase
  end

  // Loader state machine with all outputs registered
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state    <= S_IDLE;
      r_byte_idx <= 2'd0;
      r_word_cnt <= 10'd0;
      r_word     <= 32'd0;
      r_tmo      <= '0;
      r_s_ready  <= 1'b0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= 4'h0;
      r_adr      <= 32'd0;
      r_dat      <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state    <= S_COLLECT;
            r_byte_idx <= 2'd0;
            r_word_cnt <= 10'd0;
            r_word     <= 32'd0;
            r_tmo      <= '0;
            r_s_ready  <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end

        S_COLLECT: begin
          if (s_valid) begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_state   <= S_WRITE;
              r_s_ready <= 1'b0;
              r_cyc     <= 1'b1;
              r_stb     <= 1'b1;
              r_we      <= 1'b1;
              r_sel     <= 4'hF;
              r_adr     <= w_adr;
              r_dat     <= w_word_next;
              r_tmo     <= '0;
            end
          end
        end

        S_WRITE: begin
          if (wbm_ack_i) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_tmo <= '0;
`ifdef LOADER_READBACK_VERIFY_EN
            // The word is only counted once the read-back agrees
            r_state <= S_VERIFY;
`else
            r_word_cnt <= r_word_cnt + 10'd1;
            if (w_last_word) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_COLLECT;
              r_s_ready <= 1'b1;
            end
`endif
          end else if (w_tmo_hit) begin
            r_state <= S_ERROR;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_tmo   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

`ifdef LOADER_READBACK_VERIFY_EN
        S_VERIFY: begin
          if (!r_stb) begin
            // Open the read beat one cycle after the write beat closed
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= 1'b0;
            r_sel <= 4'hF;
            r_tmo <= '0;
          end else if (wbm_ack_i) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_tmo <= '0;
            if (wbm_dat_i == r_dat) begin
              r_word_cnt <= r_word_cnt + 10'd1;
              if (w_last_word) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_COLLECT;
                r_s_ready <= 1'b1;
              end
            end else begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_ERROR;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_tmo   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
`endif

        default: begin
          r_state   <= S_IDLE;
          r_s_ready <= 1'b0;
          r_cyc     <= 1'b0;
          r_stb     <= 1'b0;
          r_we      <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready       = r_s_ready;
  assign wbm_cyc_o     = r_cyc;
  assign wbm_stb_o     = r_stb;
  assign wbm_we_o      = r_we;
  assign wbm_sel_o     = r_sel;
  assign wbm_adr_o     = r_adr;
  assign wbm_dat_o     = r_dat;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign words_written = r_word_cnt;

endmodule

// File: tb/tb_wb_image_loader.sv
// Bench for wb_image_loader: a transaction-level model predicts every registered
// output each cycle for the main loader; a second one-word loader is checked directly.
module tb_wb_image_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int MW = 512;
  localparam int MT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  s_byte = 8'h00;
  logic        s_valid = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] dat_i = 32'h0;
  logic        s_ready, cyc, stb, we, busy, done, err;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic [9:0]  ww;

  logic        sm_start = 1'b0;
  logic [7:0]  sm_byte = 8'h00;
  logic        sm_valid = 1'b0;
  logic        sm_ack = 1'b0;
  logic        sm_ready, sm_cyc, sm_stb, sm_we, sm_busy, sm_done, sm_err;
  logic [3:0]  sm_sel;
  logic [31:0] sm_adr, sm_dat;
  logic [9:0]  sm_ww;

  wb_image_loader #(.BASE_ADDR(BASE), .WORDS(MW), .TIMEOUT(MT)) u_dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start(start), .s_byte(s_byte),
    .s_valid(s_valid), .s_ready(s_ready), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
    .wbm_we_o(we), .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack), .busy(busy), .done(done), .err(err),
    .words_written(ww)
  );

  wb_image_loader #(.BASE_ADDR(BASE), .WORDS(1)) u_one (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start(sm_start), .s_byte(sm_byte),
    .s_valid(sm_valid), .s_ready(sm_ready), .wbm_cyc_o(sm_cyc), .wbm_stb_o(sm_stb),
    .wbm_we_o(sm_we), .wbm_sel_o(sm_sel), .wbm_adr_o(sm_adr), .wbm_dat_o(sm_dat),
    .wbm_dat_i(dat_i), .wbm_ack_i(sm_ack), .busy(sm_busy), .done(sm_done), .err(sm_err),
    .words_written(sm_ww)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: 0 = random ack delay 0..5, 1 = never ack, 2 = ack held high
  int          resp_mode = 0;
  logic [31:0] mem [0:MW-1];
  int          n_writes = 0;
  logic [31:0] last_adr = 32'h0;

  initial begin
    int wcnt = 0;
    int cur_d = 0;
    forever begin
      @(negedge clk);
      if (resp_mode == 0) begin
        if (ack) ack = 1'b0;
        else if (stb) begin
          if (wcnt >= cur_d) begin
            ack = 1'b1;
            wcnt = 0;
            cur_d = $urandom_range(0, 5);
          end else wcnt++;
        end else wcnt = 0;
      end else if (resp_mode == 1) ack = 1'b0;
      else ack = 1'b1;
    end
  end

  // Behavioural model: bytes, word count and timeout run tracked in load terms
  initial begin
    bit          m_act = 0;
    int          m_ww = 0, m_nb = 0, m_run = 0;
    logic [31:0] m_word = 32'h0;
    logic        e_ready = 0, e_cyc = 0, e_stb = 0, e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [3:0]  e_sel = 4'h0;
    logic [31:0] e_adr = 32'h0, e_dat = 32'h0;
    bit          bus_chk;
    logic        p_stb = 0, p_we = 0;
    logic [31:0] p_adr = 32'h0, p_dat = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_chk = 0;
      if (!rst_n) begin
        m_act = 0; m_ww = 0; m_nb = 0; m_run = 0;
        e_ready = 0; e_cyc = 0; e_stb = 0; e_we = 0; e_busy = 0; e_done = 0; e_err = 0;
        e_sel = 4'h0; e_adr = 32'h0; e_dat = 32'h0;
        bus_chk = 1;
      end else begin
        if (p_stb && p_we && ack) begin
          if (((p_adr - BASE) >> 2) < MW) mem[(p_adr - BASE) >> 2] = p_dat;
          n_writes++;
          last_adr = p_adr;
        end
        if (!m_act) begin
          if (start) begin
            m_act = 1; m_ww = 0; m_nb = 0; m_run = 0;
            e_busy = 1; e_ready = 1; e_done = 0; e_err = 0;
          end
        end else if (e_stb) begin
          if (ack) begin
            m_ww++; m_run = 0;
            e_stb = 0; e_cyc = 0; e_we = 0;
            if (m_ww == MW) begin m_act = 0; e_busy = 0; e_done = 1; end
            else e_ready = 1;
          end else begin
            m_run++;
            if (m_run == MT) begin
              m_act = 0; e_stb = 0; e_cyc = 0; e_we = 0; e_busy = 0; e_err = 1;
            end else bus_chk = 1;
          end
        end else if (e_ready && s_valid) begin
          m_word[8*m_nb +: 8] = s_byte;
          m_nb++;
          if (m_nb == 4) begin
            m_nb = 0; m_run = 0;
            e_ready = 0; e_stb = 1; e_cyc = 1; e_we = 1; e_sel = 4'hF;
            e_adr = BASE + 32'(m_ww * 4);
            e_dat = m_word;
            bus_chk = 1;
          end
        end
      end
      check("s_ready", 32'(s_ready), 32'(e_ready));
      check("cyc", 32'(cyc), 32'(e_cyc));
      check("stb", 32'(stb), 32'(e_stb));
      check("we", 32'(we), 32'(e_we));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("err", 32'(err), 32'(e_err));
      check("words_written", 32'(ww), 32'(m_ww));
      if (bus_chk) begin
        check("adr", adr, e_adr);
        check("dat", dat, e_dat);
        check("sel", 32'(sel), 32'(e_sel));
      end
      p_stb = stb; p_we = we; p_adr = adr; p_dat = dat;
    end
  end

  // Present bytes first..first+n-1 with random valid gaps; returns after the last is taken
  task automatic feed(input int n, input int first);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 40000) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 2) != 0);
      s_byte  = 8'(first + idx);
      if (s_valid && s_ready) idx++;
      guard++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    if (idx < n) check("feed_timeout", 32'(idx), 32'(n));
  endtask

  initial begin
    int cnt, wr_base, bad;
    logic [31:0] exp_w;
    logic [7:0] sm_bytes [4];
    sm_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};

    // Reset held for three edges
    repeat (3) @(negedge clk);
    check("rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("rst_flags", {28'd0, busy, done, err, s_ready}, 32'd0);
    check("rst_ww", 32'(ww), 32'd0);
    check("rst_one_outputs", {sm_cyc, sm_stb, sm_busy, sm_done, sm_err, sm_ready, 26'd0}, 32'd0);
    rst_n = 1'b1;

    // One-word load on the WORDS=1 instance, ack two cycles after stb
    @(negedge clk); sm_start = 1'b1;
    @(negedge clk); sm_start = 1'b0;
    check("one_start", {30'd0, sm_busy, sm_ready}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      sm_valid = 1'b1; sm_byte = sm_bytes[i];
      @(negedge clk);
    end
    sm_valid = 1'b0;
    check("one_stb_we", {29'd0, sm_cyc, sm_stb, sm_we}, 32'd7);
    check("one_adr", sm_adr, 32'h3000_0000);
    check("one_dat", sm_dat, 32'h1234_5678);
    check("one_sel", 32'(sm_sel), 32'hF);
    check("one_ready_low", 32'(sm_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    sm_ack = 1'b1;
    @(negedge clk);
    sm_ack = 1'b0;
    check("one_done", {29'd0, sm_done, sm_busy, sm_stb}, 32'h4);
    check("one_ww", 32'(sm_ww), 32'd1);

    // Timeout: responder never acks
    resp_mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy_ready", {30'd0, busy, s_ready}, 32'd3);
    feed(4, 8'hA0);
    cnt = 0;
    while (stb && cnt < 50) begin cnt++; @(negedge clk); end
    check("timeout_stb_cycles", 32'(cnt), 32'd8);
    check("timeout_flags", {29'd0, err, busy, cyc}, 32'h4);
    check("timeout_ww", 32'(ww), 32'd0);

    // Restart from ERROR and run a full load
    resp_mode = 0;
    wr_base = n_writes;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart_err_clear", {30'd0, err, busy}, 32'd1);
    feed(4 * MW, 0);
    cnt = 0;
    while (!done && cnt < 50) begin cnt++; @(negedge clk); end
    check("full_done", {30'd0, done, busy}, 32'd2);
    check("full_ww", 32'(ww), 32'd512);
    check("full_writes", 32'(n_writes - wr_base), 32'd512);
    check("full_last_adr", last_adr, 32'h3000_07FC);
    check("mem_first", mem[0], 32'h0302_0100);
    check("mem_last", mem[MW-1], 32'hFFFE_FDFC);
    bad = 0;
    for (int i = 0; i < MW; i++) begin
      exp_w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      if (mem[i] !== exp_w) bad++;
    end
    check("sram_contents", 32'(bad), 32'd0);

    // Stream beats after DONE are not consumed
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); s_valid = 1'b1; s_byte = 8'h55;
      check("after_done_ready", 32'(s_ready), 32'd0);
    end
    @(negedge clk); s_valid = 1'b0;

    // Reset in the middle of a write beat
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    feed(4, 8'h40);
    cnt = 0;
    while (ww != 10'd1 && cnt < 50) begin cnt++; @(negedge clk); end
    check("pre_reset_ww", 32'(ww), 32'd1);
    resp_mode = 1;
    feed(4, 8'h44);
    @(negedge clk);
    check("pre_reset_stb", 32'(stb), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_bus", {30'd0, cyc, stb}, 32'd0);
    check("mid_reset_ww", 32'(ww), 32'd0);
    rst_n = 1'b1;
    resp_mode = 2;
    repeat (3) @(negedge clk);
    resp_mode = 1;
    @(negedge clk);
    check("late_ack_ignored", {28'd0, cyc, busy, done, err}, 32'd0);
    check("late_ack_ww", 32'(ww), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
